hazard_ctrl: RTL and testbench

- Pipeline hazard controller: the consumer of the ID/EX stage register's outputs and the producer of its flush/stall controls.
- Detects load-use hazards and taken jumps/branches, and drives stall/flush to PC, IF/ID and ID/EX.
- Generates EX-stage operand forwarding selects from the EX/MEM and MEM/WB destination tags.
- Sits beside the 5-stage datapath in the CPU top.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd_sel.sv | 28 ++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
// Forwarding select encodings, the x0 register id and the stall FSM states.
package hazard_pkg;

  // Operand source selects for the EX-stage ALU inputs
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // x0 is hardwired to zero and is never a hazard or forwarding source
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    LDSTALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Purpose: forwarding select for one EX operand (EX/MEM beats MEM/WB, x0 never forwards).
// Latency: purely combinational, zero cycles.
// Backpressure: none; a disabled operand always selects the register file.
import hazard_pkg::*;

module fwd_sel (
  input  logic       i_en,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_we,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_we,
  output logic [1:0] o_sel
);

  // Priority compare: the younger EX/MEM result shadows the older MEM/WB one
  always_comb begin
    o_sel = FWD_RF;
    if (i_en) begin
      if (i_mem_we && (i_mem_rd != REG_X0) && (i_mem_rd == i_rs)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_we && (i_wb_rd != REG_X0) && (i_wb_rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: load-use stall / jump flush control and EX operand forwarding; HAZARD_PERF_EN adds perf counters.
// Latency: controls combinational in the detecting cycle; extended load stalls last LOAD_STALL_CYCLES total.
// Backpressure: stalls PC and IF/ID while bubbling ID/EX; taken jump flushes IF/ID and ID/EX.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       ex_hasrs2,
  input  logic       ex_without_rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_jump_taken,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_reg_write,
  input  logic       wb_reg_write,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       w_hazard_lu;

  // Load in EX whose destination is read by the instruction in ID
  assign w_hazard_lu = ex_mem_read && (ex_rd != REG_X0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

  // State and remaining-bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and stall/flush controls; reset forces every control low
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_jump_taken) begin
          // ID holds a wrong-path instruction, so its hazard is irrelevant
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_hazard_lu) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = LDSTALL;
            w_cnt_nxt   = 3'(LOAD_STALL_CYCLES - 2);
          end
        end
      end
      LDSTALL: begin
        // EX carries a bubble here, so a jump indication is spurious
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (r_cnt == 3'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
    if (rst) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  fwd_sel u_fwd_a (
    .i_en     (!ex_without_rs),
    .i_rs     (ex_rs1),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_reg_write),
    .o_sel    (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_en     (ex_hasrs2 && !ex_without_rs),
    .i_rs     (ex_rs2),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_reg_write),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_reg_write),
    .o_sel    (w_fwd_b)
  );

  assign fwd_a = rst ? FWD_RF : w_fwd_a;
  assign fwd_b = rst ? FWD_RF : w_fwd_b;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters; a flush is only ever caused by a taken jump
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (pc_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (ifid_flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_events = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl (default and 3-cycle load stall builds side by side).
// Latency: outputs checked 1 time unit after each negedge input change, model advanced at posedge.
// Backpressure: n/a; perf counters are checked when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_hasrs2, ex_without_rs;
  logic       ex_mem_read, ex_jump_taken, mem_reg_write, wb_reg_write;

  logic       pcs1, ifs1, iff1, idf1, pcs3, ifs3, iff3, idf3;
  logic [1:0] fa1, fb1, fa3, fb3;
`ifdef HAZARD_PERF_EN
  logic [31:0] ps1_o, pf1_o, ps3_o, pf3_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model: bubbles still owed by each DUT, and expected perf counts
  int          rem1 = 0;
  int          rem3 = 0;
  logic [31:0] mps1 = 0, mpf1 = 0, mps3 = 0, mpf3 = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_hasrs2(ex_hasrs2),
    .ex_without_rs(ex_without_rs), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_jump_taken(ex_jump_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_stall(pcs1), .ifid_stall(ifs1), .ifid_flush(iff1), .idex_flush(idf1),
    .fwd_a(fa1), .fwd_b(fb1)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(ps1_o), .perf_flush_events(pf1_o)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_hasrs2(ex_hasrs2),
    .ex_without_rs(ex_without_rs), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_jump_taken(ex_jump_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_stall(pcs3), .ifid_stall(ifs3), .ifid_flush(iff3), .idex_flush(idf3),
    .fwd_a(fa3), .fwd_b(fb3)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(ps3_o), .perf_flush_events(pf3_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic hazard();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic en);
    if (rst || !en) return 2'b00;
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {pc_stall, ifid_stall, ifid_flush, idex_flush} given bubbles owed
  function automatic logic [3:0] ctl_model(input int rem);
    if (rst) return 4'b0000;
    if (rem > 0) return 4'b1101;
    if (ex_jump_taken) return 4'b0011;
    if (hazard()) return 4'b1101;
    return 4'b0000;
  endfunction

  // Compare every DUT output against the model for the current inputs
  task automatic settle();
    #1;
    chk("ctl_n1", {pcs1, ifs1, iff1, idf1}, ctl_model(rem1));
    chk("ctl_n3", {pcs3, ifs3, iff3, idf3}, ctl_model(rem3));
    chk("fwd_a", {fa1, fa3}, {2{fwd_model(ex_rs1, !ex_without_rs)}});
    chk("fwd_b", {fb1, fb3}, {2{fwd_model(ex_rs2, ex_hasrs2 && !ex_without_rs)}});
`ifdef HAZARD_PERF_EN
    chk("perf_stall_n1", ps1_o, mps1);
    chk("perf_flush_n1", pf1_o, mpf1);
    chk("perf_stall_n3", ps3_o, mps3);
    chk("perf_flush_n3", pf3_o, mpf3);
`endif
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Advance the model across one clock edge, then move to the next negedge
  task automatic adv();
    logic [3:0] c1, c3;
    c1 = ctl_model(rem1);
    c3 = ctl_model(rem3);
    @(posedge clk);
    if (rst) begin
      rem1 = 0; rem3 = 0; mps1 = 0; mpf1 = 0; mps3 = 0; mpf3 = 0;
    end else begin
      mps1 = sat_inc(mps1, c1[3]); mpf1 = sat_inc(mpf1, c1[1]);
      mps3 = sat_inc(mps3, c3[3]); mpf3 = sat_inc(mpf3, c3[1]);
      if (rem1 > 0) rem1--;
      else if (!ex_jump_taken && hazard()) rem1 = 1 - 1;
      if (rem3 > 0) rem3--;
      else if (!ex_jump_taken && hazard()) rem3 = 3 - 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_hasrs2, ex_without_rs} = '0;
    {ex_mem_read, ex_jump_taken, mem_reg_write, wb_reg_write} = '0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    // Reset held two cycles with an active load-use hazard: all outputs low
    load_use(5'd5);
    mem_reg_write = 1'b1; mem_rd = 5'd5; ex_rs1 = 5'd5;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("rst_ctl", {pcs1, ifs1, iff1, idf1, pcs3, ifs3, iff3, idf3}, 8'h00);
      chk("rst_fwd_a", {fa1, fa3}, 4'b0000);
      adv();
    end
    rst = 1'b0;
    // One-cycle load-use pulse: 1 bubble for N=1, 3 bubbles for N=3
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("lu_n1_stall", {pcs1, ifs1, idf1}, (k < 1) ? 3'b111 : 3'b000);
      chk("lu_n3_stall", {pcs3, ifs3, idf3}, (k < 3) ? 3'b111 : 3'b000);
      adv();
      idle();
    end
    // Load into x0 is never a hazard
    load_use(5'd0); id_rs1 = 5'd0;
    settle();
    chk("lu_x0", {pcs1, pcs3}, 2'b00);
    adv(); idle();
    // Reset in the second bubble cycle cancels the extended stall
    load_use(5'd9); id_rs1 = 5'd9;
    settle(); adv(); idle();
    rst = 1'b1;
    settle();
    chk("lu_rst_mid", pcs3, 1'b0);
    adv(); rst = 1'b0;
    settle();
    chk("lu_rst_run", pcs3, 1'b0);
    adv();
    // Jump beats load-use: flush only, no extended stall afterwards
    load_use(5'd4); id_rs1 = 5'd4; ex_jump_taken = 1'b1;
    settle();
    chk("jmp_pri", {pcs3, ifs3, iff3, idf3}, 4'b0011);
    adv(); idle();
    settle();
    chk("jmp_no_ldstall", {pcs3, idf3}, 2'b00);
    adv();
    // Forwarding priority and gating
    ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_hasrs2 = 1'b0;
    settle();
    chk("fwd_a_mem", fa1, 2'b10);
    chk("fwd_b_nors2", fb1, 2'b00);
    mem_reg_write = 1'b0;
    settle();
    chk("fwd_a_wb", fa1, 2'b01);
    ex_without_rs = 1'b1;
    settle();
    chk("fwd_a_norsreg", fa1, 2'b00);
    ex_without_rs = 1'b0; ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_reg_write = 1'b1;
    settle();
    chk("fwd_a_x0", fa1, 2'b00);
    adv(); idle();
`ifdef HAZARD_PERF_EN
    // Fresh counters: one 3-bubble load stall plus two jumps
    rst = 1'b1; settle(); adv(); rst = 1'b0;
    load_use(5'd3); id_rs1 = 5'd3;
    settle(); adv(); idle();
    settle(); adv(); settle(); adv();
    ex_jump_taken = 1'b1; settle(); adv();
    idle(); settle(); adv();
    ex_jump_taken = 1'b1; settle(); adv();
    idle(); settle();
    chk("perf_stall_lit", ps3_o, 32'd3);
    chk("perf_flush_lit", pf3_o, 32'd2);
    adv();
`endif
    // Randomized traffic over a small register range to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_uses_rs1   = 1'($urandom_range(0, 1));
      id_uses_rs2   = 1'($urandom_range(0, 1));
      ex_rs1        = 5'($urandom_range(0, 3));
      ex_rs2        = 5'($urandom_range(0, 3));
      ex_hasrs2     = 1'($urandom_range(0, 1));
      ex_without_rs = ($urandom_range(0, 7) == 0);
      ex_rd         = 5'($urandom_range(0, 3));
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_jump_taken = ($urandom_range(0, 7) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      settle();
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
